// File: rtl/cdt_wb_pipe.sv
// cdt_wb_pipe: register-write request pipeline from the D/E boundary to W.
// Each stage carries instruction, PC, effective destination, remaining Tnew
// and forwarding data. Conditional writes (movz, bgezal) are resolved at
// entry, and a cancelled write becomes a write to $0 so it never
// creates a hazard downstream.
module cdt_wb_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D_Instr,
  input  logic [31:0] D_PC,
  input  logic [4:0]  D_A3,
  input  logic        D_RegWE,
  input  logic        D_CdtWE,
  input  logic [1:0]  D_Tnew,
  input  logic [31:0] D_LinkWD,
  input  logic        Stall,
  input  logic [31:0] E_ALUOut,
  input  logic [31:0] M_DMOut,
  output logic [31:0] E_Instr,
  output logic [31:0] M_Instr,
  output logic [31:0] W_Instr,
  output logic [31:0] E_PC,
  output logic [31:0] M_PC,
  output logic [31:0] W_PC,
  output logic [4:0]  E_A3,
  output logic [4:0]  M_A3,
  output logic [4:0]  W_A3,
  output logic [1:0]  E_Tnew,
  output logic [1:0]  M_Tnew,
  output logic [31:0] E_WD,
  output logic [31:0] M_WD,
  output logic        W_WE,
  output logic [31:0] W_WD
);

  // Entry resolution in D
  logic        d_we;
  logic [4:0]  d_a3_eff;
  logic [1:0]  d_tnew_sat;

  // E stage
  logic [31:0] e_instr_q, e_instr_d;
  logic [31:0] e_pc_q,    e_pc_d;
  logic [4:0]  e_a3_q,    e_a3_d;
  logic [1:0]  e_tnew_q,  e_tnew_d;
  logic [31:0] e_wd_q,    e_wd_d;

  // M stage
  logic [31:0] m_instr_q, m_instr_d;
  logic [31:0] m_pc_q,    m_pc_d;
  logic [4:0]  m_a3_q,    m_a3_d;
  logic [1:0]  m_tnew_q,  m_tnew_d;
  logic [31:0] m_wd_q,    m_wd_d;

  // W stage
  logic [31:0] w_instr_q, w_instr_d;
  logic [31:0] w_pc_q,    w_pc_d;
  logic [4:0]  w_a3_q,    w_a3_d;
  logic        w_we_q,    w_we_d;
  logic [31:0] w_wd_q,    w_wd_d;

  // Next-state for every stage: entry resolution, stall bubble, Tnew aging
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    d_we       = (D_RegWE | D_CdtWE) & (D_A3 != 5'd0);
    d_a3_eff   = d_we ? D_A3 : 5'd0;
    // Tnew of 3 is illegal; treat it as a load (2).
    d_tnew_sat = (D_Tnew == 2'd3) ? 2'd2 : D_Tnew;

    e_instr_d  = '0;
    e_pc_d     = '0;
    e_a3_d     = '0;
    e_tnew_d   = '0;
    e_wd_d     = '0;
    if (!Stall) begin
      e_instr_d = D_Instr;
      e_pc_d    = D_PC;
      e_a3_d    = d_a3_eff;
      e_tnew_d  = d_tnew_sat;
      e_wd_d    = (d_tnew_sat == 2'd0) ? D_LinkWD : 32'd0;
    end

    m_instr_d  = e_instr_q;
    m_pc_d     = e_pc_q;
    m_a3_d     = e_a3_q;
    m_tnew_d   = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    m_wd_d     = (e_tnew_q == 2'd1) ? E_ALUOut : e_wd_q;

    w_instr_d  = m_instr_q;
    w_pc_d     = m_pc_q;
    w_a3_d     = m_a3_q;
    w_we_d     = (m_a3_q != 5'd0);
    w_wd_d     = (m_tnew_q == 2'd1) ? M_DMOut : m_wd_q;
  end

  // Stage registers; synchronous active-low reset clears every stage
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all stages
    // sample the pre-edge values and shift together.
    if (!reset) begin
      e_instr_q <= '0;
      e_pc_q    <= '0;
      e_a3_q    <= '0;
      e_tnew_q  <= '0;
      e_wd_q    <= '0;
      m_instr_q <= '0;
      m_pc_q    <= '0;
      m_a3_q    <= '0;
      m_tnew_q  <= '0;
      m_wd_q    <= '0;
      w_instr_q <= '0;
      w_pc_q    <= '0;
      w_a3_q    <= '0;
      w_we_q    <= 1'b0;
      w_wd_q    <= '0;
    end else begin
      e_instr_q <= e_instr_d;
      e_pc_q    <= e_pc_d;
      e_a3_q    <= e_a3_d;
      e_tnew_q  <= e_tnew_d;
      e_wd_q    <= e_wd_d;
      m_instr_q <= m_instr_d;
      m_pc_q    <= m_pc_d;
      m_a3_q    <= m_a3_d;
      m_tnew_q  <= m_tnew_d;
      m_wd_q    <= m_wd_d;
      w_instr_q <= w_instr_d;
      w_pc_q    <= w_pc_d;
      w_a3_q    <= w_a3_d;
      w_we_q    <= w_we_d;
      w_wd_q    <= w_wd_d;
    end
  end

  assign E_Instr = e_instr_q;
  assign E_PC    = e_pc_q;
  assign E_A3    = e_a3_q;
  assign E_Tnew  = e_tnew_q;
  assign E_WD    = e_wd_q;
  assign M_Instr = m_instr_q;
  assign M_PC    = m_pc_q;
  assign M_A3    = m_a3_q;
  assign M_Tnew  = m_tnew_q;
  assign M_WD    = m_wd_q;
  assign W_Instr = w_instr_q;
  assign W_PC    = w_pc_q;
  assign W_A3    = w_a3_q;
  assign W_WE    = w_we_q;
  assign W_WD    = w_wd_q;

endmodule

// File: tb/tb_cdt_wb_pipe.sv
// Testbench for cdt_wb_pipe: directed scenarios plus randomized traffic,
// every cycle compared against a history-based reference model that derives
// each stage's contents from the instruction issued k edges earlier.
module tb_cdt_wb_pipe;

  logic        clk;
  logic        reset;
  logic [31:0] D_Instr, D_PC, D_LinkWD, E_ALUOut, M_DMOut;
  logic [4:0]  D_A3;
  logic        D_RegWE, D_CdtWE, Stall;
  logic [1:0]  D_Tnew;
  logic [31:0] E_Instr, M_Instr, W_Instr, E_PC, M_PC, W_PC, E_WD, M_WD, W_WD;
  logic [4:0]  E_A3, M_A3, W_A3;
  logic [1:0]  E_Tnew, M_Tnew;
  logic        W_WE;

  int checks = 0;
  int errors = 0;

  cdt_wb_pipe dut (
    .clk(clk), .reset(reset),
    .D_Instr(D_Instr), .D_PC(D_PC), .D_A3(D_A3), .D_RegWE(D_RegWE),
    .D_CdtWE(D_CdtWE), .D_Tnew(D_Tnew), .D_LinkWD(D_LinkWD), .Stall(Stall),
    .E_ALUOut(E_ALUOut), .M_DMOut(M_DMOut),
    .E_Instr(E_Instr), .M_Instr(M_Instr), .W_Instr(W_Instr),
    .E_PC(E_PC), .M_PC(M_PC), .W_PC(W_PC),
    .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3),
    .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
    .E_WD(E_WD), .M_WD(M_WD), .W_WE(W_WE), .W_WD(W_WD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What was presented to the DUT at one rising edge
  typedef struct {
    bit          rst;
    bit          stall;
    logic [31:0] instr, pc, link, alu, dm;
    logic [4:0]  a3;
    bit          regwe, cdtwe;
    logic [1:0]  tnew;
  } edge_t;

  edge_t hist[0:4095];
  int    n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  // Instruction issued at edge k survives to edge e if it was not a bubble
  // and no reset happened at or after its issue.
  function automatic bit live(int k, int e);
    if (k < 0) return 1'b0;
    if (hist[k].stall) return 1'b0;
    for (int j = k; j <= e; j++) if (hist[j].rst) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [4:0] eff_a3(int k);
    return ((hist[k].regwe || hist[k].cdtwe) && hist[k].a3 != 0) ? hist[k].a3 : 5'd0;
  endfunction

  function automatic int eff_tnew(int k);
    return (hist[k].tnew == 2'd3) ? 2 : int'(hist[k].tnew);
  endfunction

  // Compare all outputs after edge e against the model
  task automatic check_all(input int e);
    int t;
    logic [31:0] wd;
    // E holds what was issued at edge e
    if (live(e, e)) begin
      t = eff_tnew(e);
      check("E_Instr", E_Instr, hist[e].instr);
      check("E_PC", E_PC, hist[e].pc);
      check("E_A3", {27'd0, E_A3}, {27'd0, eff_a3(e)});
      check("E_Tnew", {30'd0, E_Tnew}, t);
      check("E_WD", E_WD, (t == 0) ? hist[e].link : 32'd0);
    end else begin
      check("E_Instr", E_Instr, 0); check("E_PC", E_PC, 0);
      check("E_A3", {27'd0, E_A3}, 0); check("E_Tnew", {30'd0, E_Tnew}, 0);
      check("E_WD", E_WD, 0);
    end
    // M holds what was issued one edge earlier
    if (live(e - 1, e)) begin
      t = eff_tnew(e - 1);
      wd = (t == 1) ? hist[e].alu : (t == 0) ? hist[e-1].link : 32'd0;
      check("M_Instr", M_Instr, hist[e-1].instr);
      check("M_PC", M_PC, hist[e-1].pc);
      check("M_A3", {27'd0, M_A3}, {27'd0, eff_a3(e - 1)});
      check("M_Tnew", {30'd0, M_Tnew}, (t > 0) ? t - 1 : 0);
      check("M_WD", M_WD, wd);
    end else begin
      check("M_Instr", M_Instr, 0); check("M_PC", M_PC, 0);
      check("M_A3", {27'd0, M_A3}, 0); check("M_Tnew", {30'd0, M_Tnew}, 0);
      check("M_WD", M_WD, 0);
    end
    // W holds what was issued two edges earlier
    if (live(e - 2, e)) begin
      t = eff_tnew(e - 2);
      wd = (t == 2) ? hist[e].dm : (t == 1) ? hist[e-1].alu : hist[e-2].link;
      check("W_Instr", W_Instr, hist[e-2].instr);
      check("W_PC", W_PC, hist[e-2].pc);
      check("W_A3", {27'd0, W_A3}, {27'd0, eff_a3(e - 2)});
      check("W_WE", {31'd0, W_WE}, {31'd0, eff_a3(e - 2) != 0});
      check("W_WD", W_WD, wd);
    end else begin
      check("W_Instr", W_Instr, 0); check("W_PC", W_PC, 0);
      check("W_A3", {27'd0, W_A3}, 0); check("W_WE", {31'd0, W_WE}, 0);
      check("W_WD", W_WD, 0);
    end
  endtask

  // One clock: record the presented inputs, then check after the edge
  task automatic cycle();
    edge_t cur;
    cur.rst = !reset; cur.stall = Stall; cur.instr = D_Instr; cur.pc = D_PC;
    cur.link = D_LinkWD; cur.alu = E_ALUOut; cur.dm = M_DMOut; cur.a3 = D_A3;
    cur.regwe = D_RegWE; cur.cdtwe = D_CdtWE; cur.tnew = D_Tnew;
    @(posedge clk);
    hist[n] = cur;
    @(negedge clk);
    check_all(n);
    n++;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [4:0] a3,
                       input bit regwe, input bit cdtwe, input logic [1:0] tnew,
                       input logic [31:0] link);
    D_Instr = instr; D_PC = 32'h3000 + 32'(n * 4); D_A3 = a3;
    D_RegWE = regwe; D_CdtWE = cdtwe; D_Tnew = tnew; D_LinkWD = link;
  endtask

  task automatic idle();
    issue(32'h0, 5'd0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  initial begin
    reset = 1'b0; Stall = 1'b0; E_ALUOut = '0; M_DMOut = '0;
    idle();
    @(negedge clk);
    cycle(); cycle();
    reset = 1'b1;

    // addu $3 with ALU result 0x1234
    issue(32'h00221821, 5'd3, 1'b1, 1'b0, 2'd1, 32'h0);
    cycle();
    idle(); E_ALUOut = 32'h1234;
    cycle();
    check("addu_M_A3", {27'd0, M_A3}, 32'd3);
    check("addu_M_Tnew", {30'd0, M_Tnew}, 32'd0);
    check("addu_M_WD", M_WD, 32'h1234);
    E_ALUOut = 32'h0;
    cycle();
    check("addu_W_WE", {31'd0, W_WE}, 32'd1);
    check("addu_W_WD", W_WD, 32'h1234);

    // movz $5 cancelled, then movz $5 taken
    issue(32'h0000280a, 5'd5, 1'b0, 1'b0, 2'd1, 32'h0); E_ALUOut = 32'h55;
    cycle();
    issue(32'h0000280a, 5'd5, 1'b0, 1'b1, 2'd1, 32'h0); E_ALUOut = 32'h66;
    cycle();
    check("movz_nc_M_A3", {27'd0, M_A3}, 32'd0);
    idle(); E_ALUOut = 32'h77;
    cycle();
    check("movz_nc_W_WE", {31'd0, W_WE}, 32'd0);
    cycle();
    check("movz_c_W_A3", {27'd0, W_A3}, 32'd5);
    check("movz_c_W_WE", {31'd0, W_WE}, 32'd1);

    // bgezal taken, then untaken
    issue(32'h04110004, 5'd31, 1'b0, 1'b1, 2'd0, 32'h3008);
    cycle();
    check("bgezal_E_WD", E_WD, 32'h3008);
    check("bgezal_E_Tnew", {30'd0, E_Tnew}, 32'd0);
    issue(32'h04110004, 5'd31, 1'b0, 1'b0, 2'd0, 32'h3010);
    cycle();
    check("bgezal_nt_E_A3", {27'd0, E_A3}, 32'd0);
    idle();
    cycle();
    check("bgezal_W_WD", W_WD, 32'h3008);
    check("bgezal_W_A3", {27'd0, W_A3}, 32'd31);
    cycle();
    check("bgezal_nt_W_WE", {31'd0, W_WE}, 32'd0);

    // lw $7 followed by a two-cycle stall
    issue(32'h8c070000, 5'd7, 1'b1, 1'b0, 2'd2, 32'h0);
    cycle();
    idle(); Stall = 1'b1; D_A3 = 5'd9; D_RegWE = 1'b1;
    cycle();
    check("lw_E_bubble", {27'd0, E_A3}, 32'd0);
    check("lw_M_Tnew", {30'd0, M_Tnew}, 32'd1);
    M_DMOut = 32'hBEEF;
    cycle();
    check("lw_W_WD", W_WD, 32'hBEEF);
    check("lw_W_A3", {27'd0, W_A3}, 32'd7);
    Stall = 1'b0; M_DMOut = 32'h0; idle();
    cycle();
    check("bubble_W_WE", {31'd0, W_WE}, 32'd0);
    cycle();

    // A3=0 unconditional write, and illegal Tnew=3 treated as a load
    issue(32'h00000821, 5'd0, 1'b1, 1'b0, 2'd1, 32'h0);
    cycle();
    issue(32'h8c0a0000, 5'd10, 1'b1, 1'b0, 2'd3, 32'h0);
    cycle();
    check("tnew3_E_Tnew", {30'd0, E_Tnew}, 32'd2);
    idle(); cycle(); cycle();

    // Reset with three writes in flight
    issue(32'h1, 5'd1, 1'b1, 1'b0, 2'd1, 32'h0); E_ALUOut = 32'hA1; cycle();
    issue(32'h2, 5'd2, 1'b1, 1'b0, 2'd0, 32'h4444); E_ALUOut = 32'hA2; cycle();
    issue(32'h3, 5'd3, 1'b1, 1'b0, 2'd2, 32'h0); E_ALUOut = 32'hA3; cycle();
    reset = 1'b0; M_DMOut = 32'hDEAD;
    cycle();
    check("rst_W_WE", {31'd0, W_WE}, 32'd0);
    check("rst_M_A3", {27'd0, M_A3}, 32'd0);
    reset = 1'b1; idle();
    cycle();
    check("rst_W_WE_1", {31'd0, W_WE}, 32'd0);
    cycle();
    check("rst_W_WE_2", {31'd0, W_WE}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      reset    = ($urandom_range(0, 49) != 0);
      Stall    = ($urandom_range(0, 4) == 0);
      D_Instr  = $urandom;
      D_PC     = $urandom;
      D_A3     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      D_RegWE  = 1'($urandom);
      D_CdtWE  = ($urandom_range(0, 3) == 0);
      D_Tnew   = 2'($urandom);
      D_LinkWD = $urandom;
      E_ALUOut = $urandom;
      M_DMOut  = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdt_wb_pipe.md
# cdt_wb_pipe

Pipeline register chain carrying each instruction's resolved register-write request (destination, write enable, result data, Tnew) from the D/E boundary through E, M and W. It consumes the conditional write-enable resolved in D for `movz`/`bgezal` and turns conditionally-cancelled writes into writes to `$0`. It supplies the hazard/forwarding unit with per-stage A3/Tnew/WD and drives the GRF write port from W.

## Interface
- `clk`  in  1  system clock; all state updates on posedge
- `reset`  in  1  synchronous, active-low; sampled on posedge
- `D_Instr`  in  32  instruction leaving D
- `D_PC`  in  32  its PC
- `D_A3`  in  5  decoded destination register
- `D_RegWE`  in  1  unconditional write request (R-type ALU, load, jal, …)
- `D_CdtWE`  in  1  conditional write resolved in D (movz rt==0, bgezal taken)
- `D_Tnew`  in  2  cycles until result ready, measured at E entry (0 = link/PC+8, 1 = ALU, 2 = load)
- `D_LinkWD`  in  32  PC+8 for link writes; used only when `D_Tnew`==0
- `Stall`  in  1  hazard stall: E receives a bubble, M/W advance
- `E_ALUOut`  in  32  E-stage result
- `M_DMOut`  in  32  M-stage load data
- `E_Instr`, `M_Instr`, `W_Instr`  out  32  stage instruction words
- `E_PC`, `M_PC`, `W_PC`  out  32  stage PCs
- `E_A3`, `M_A3`, `W_A3`  out  5  effective destination (0 if no write)
- `E_Tnew`, `M_Tnew`  out  2  remaining cycles to result
- `E_WD`, `M_WD`  out  32  forwarding data, valid only when stage Tnew==0
- `W_WE`  out  1  GRF write enable
- `W_WD`  out  32  GRF write data

## Operation
- Entry resolution, combinational in D: `we = (D_RegWE | D_CdtWE) & (D_A3 != 0)`. Effective A3 = `we ? D_A3 : 0`. A cancelled `movz` or an untaken `bgezal` therefore enters E with A3=0 and never stalls consumers.
- D→E on each clock when `Stall`=0: latch Instr, PC, effective A3, D_Tnew. E_WD = D_LinkWD if D_Tnew==0, else 0.
- D→E when `Stall`=1: E loads a bubble (Instr=0, PC=0, A3=0, Tnew=0, WD=0).
- E→M on every clock: A3, Instr and PC copied. M_Tnew = (E_Tnew==0) ? 0 : E_Tnew-1. M_WD = E_ALUOut if E_Tnew==1, else E_WD.
- M→W on every clock: W_A3 = M_A3. W_WD = M_DMOut if M_Tnew==1, else M_WD. W_WE = (M_A3 != 0).
- Tnew is saturating at 0 and never underflows. An entry Tnew of 3 is illegal and is treated as 2.
- A write to `$0` is never asserted: W_WE=0 whenever W_A3==0.
- No internal stall or flush of M/W. The block holds no other state.

## Timing
- Reset: every output, including Instr/PC/A3/Tnew/WD/W_WE, is 0 on the first posedge with `reset`=0. Reset overrides `Stall` and all data inputs.
- Reset mid-operation discards all in-flight writes. No GRF write is issued on the reset edge or the edge that follows it.
- Latency: D→W is 3 clocks with no stall. Each stall cycle inserts exactly one bubble, which reaches W 2 cycles later.
- Forwarding: E_WD/M_WD are registered outputs, valid in the same cycle their Tnew reads 0.
- A `Stall` held for N cycles produces N consecutive bubbles. M/W keep draining, so an older load completes normally.
- Back-to-back writes to the same register leave W in program order. No reordering is possible.

## Test plan
- After reset, `addu $3` (RegWE=1, A3=3, Tnew=1) is issued with E_ALUOut=0x1234 in its E cycle -> M_A3=3, M_Tnew=0, M_WD=0x1234; next cycle W_WE=1, W_A3=3, W_WD=0x1234.
- `movz $5` with CdtWE=0, RegWE=0 -> E_A3=0 through W; W_WE=0 at its W cycle.
- `movz $5` with CdtWE=1 -> same as above, except W_WE=1 and W_A3=5.
- `bgezal` taken (CdtWE=1, A3=31, Tnew=0, LinkWD=0x3008) -> E_WD=0x3008, E_Tnew=0; W_WD=0x3008, W_A3=31.
- `bgezal` untaken -> A3=0 in all stages.
- `lw $7` (Tnew=2) followed by `Stall`=1 for 2 cycles -> E shows two bubbles (A3=0), M_Tnew=1 then W_WD=M_DMOut=0xBEEF, W_A3=7; bubbles reach W with W_WE=0.
- `reset` driven low while three writes are in flight -> all outputs 0 next edge; W_WE stays 0 for the following 2 cycles even with `reset` released.
- Write with A3=0 (RegWE=1) -> W_WE=0 throughout.
